ibus_arbiter: RTL and testbench

Three-master arbiter that shares the CPU internal bus (IBUS) port of the bus state controller between the DMAC, CPU data access and CPU instruction fetch. It registers a one-hot grant and drives the single downstream IBUS from the owner. It stalls losing masters through their BUSY lines and holds ownership across locked sequences (TAS, DMAC burst). It sits between the CPU core/DMAC and the bus state controller, in the CE_R/CE_F clock-enable domain.

---
 rtl/ibus_arbiter_pkg.sv | 25 ++
 rtl/ibus_arb_pick.sv | 53 +++++
 rtl/ibus_arbiter.sv | 134 +++++++++++++
 tb/tb_ibus_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ibus_arbiter_pkg.sv
// Shared types and constants for the IBUS three-master arbiter.
// Master indices: DMAC, CPU data, CPU instruction fetch.
package ibus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOwn,
        StLocked
    } ibus_arb_state_t;

    localparam logic [1:0] IBA_DMAC = 2'd0;
    localparam logic [1:0] IBA_DATA = 2'd1;
    localparam logic [1:0] IBA_INST = 2'd2;

    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        if (oh[1]) return IBA_DATA;
        if (oh[2]) return IBA_INST;
        return IBA_DMAC;
    endfunction

endpackage

// File: rtl/ibus_arb_pick.sv
// Combinational winner picker. Macro IBUS_ARB_RR_EN selects round-robin starting after LAST;
// otherwise fixed priority M0 > M1 > M2.
module ibus_arb_pick
    import ibus_arbiter_pkg::*;
(
    input  logic [2:0] REQ,
    input  logic [1:0] LAST,
    output logic [2:0] WIN,
    output logic [1:0] WIN_IDX
);

`ifdef IBUS_ARB_RR_EN
    logic [1:0] first, second, third;

    always_comb begin
        unique case (LAST)
            2'd0: begin
                first  = IBA_DATA;
                second = IBA_INST;
                third  = IBA_DMAC;
            end
            2'd1: begin
                first  = IBA_INST;
                second = IBA_DMAC;
                third  = IBA_DATA;
            end
            default: begin
                first  = IBA_DMAC;
                second = IBA_DATA;
                third  = IBA_INST;
            end
        endcase

        WIN = 3'b000;
        if (REQ[first]) WIN = idx_to_onehot(first);
        else if (REQ[second]) WIN = idx_to_onehot(second);
        else if (REQ[third]) WIN = idx_to_onehot(third);
    end
`else
    logic [1:0] unused_last;
    assign unused_last = LAST;

    always_comb begin
        WIN = 3'b000;
        if (REQ[0]) WIN = 3'b001;
        else if (REQ[1]) WIN = 3'b010;
        else if (REQ[2]) WIN = 3'b100;
    end
`endif

    assign WIN_IDX = onehot_to_idx(WIN);

endmodule

// File: rtl/ibus_arbiter.sv
// Three-master IBUS arbiter: registered one-hot grant, owner mux, lock holding.
// Build with IBUS_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module ibus_arbiter
    import ibus_arbiter_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [31:0] M0_A,
    input  logic [31:0] M0_DI,
    input  logic [3:0]  M0_BA,
    input  logic        M0_WE,
    input  logic        M0_REQ,
    input  logic        M0_LOCK,
    output logic        M0_BUSY,
    input  logic [31:0] M1_A,
    input  logic [31:0] M1_DI,
    input  logic [3:0]  M1_BA,
    input  logic        M1_WE,
    input  logic        M1_REQ,
    input  logic        M1_LOCK,
    output logic        M1_BUSY,
    input  logic [31:0] M2_A,
    input  logic [31:0] M2_DI,
    input  logic [3:0]  M2_BA,
    input  logic        M2_WE,
    input  logic        M2_REQ,
    input  logic        M2_LOCK,
    output logic        M2_BUSY,
    output logic [31:0] M_DO,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    output logic        IBUS_LOCK,
    input  logic [31:0] IBUS_DO,
    input  logic        IBUS_BUSY,
    output logic [2:0]  GNT
);

    ibus_arb_state_t state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] last_q, last_d;
    logic [2:0] req, lock, win;
    logic [1:0] win_idx;
    logic       owner_req, owner_lock, done;

    logic unused_ce_f;
    assign unused_ce_f = CE_F;

    assign req  = {M2_REQ, M1_REQ, M0_REQ};
    assign lock = {M2_LOCK, M1_LOCK, M0_LOCK};

    assign owner_req  = |(gnt_q & req);
    assign owner_lock = |(gnt_q & lock);
    assign done       = owner_req & ~IBUS_BUSY;

    ibus_arb_pick u_pick (
        .REQ    (req),
        .LAST   (last_q),
        .WIN    (win),
        .WIN_IDX(win_idx)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            gnt_q   <= 3'b000;
            last_q  <= IBA_INST;
        end else if (CE_R) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StOwn;
                    gnt_d   = win;
                    last_d  = win_idx;
                end
            end
            StOwn: begin
                if (!owner_req) begin
                    state_d = StIdle;
                    gnt_d   = 3'b000;
                end else if (done) begin
                    state_d = owner_lock ? StLocked : StIdle;
                    gnt_d   = owner_lock ? gnt_q : 3'b000;
                end
            end
            StLocked: begin
                // A pending owner access proceeds as in OWN; an idle owner holds while locked.
                if (owner_req) begin
                    if (done) begin
                        state_d = owner_lock ? StLocked : StIdle;
                        gnt_d   = owner_lock ? gnt_q : 3'b000;
                    end
                end else if (!owner_lock) begin
                    state_d = StIdle;
                    gnt_d   = 3'b000;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 3'b000;
            end
        endcase
    end

    assign IBUS_A  = ({32{gnt_q[0]}} & M0_A)  | ({32{gnt_q[1]}} & M1_A)  | ({32{gnt_q[2]}} & M2_A);
    assign IBUS_DI = ({32{gnt_q[0]}} & M0_DI) | ({32{gnt_q[1]}} & M1_DI) | ({32{gnt_q[2]}} & M2_DI);
    assign IBUS_BA = ({4{gnt_q[0]}} & M0_BA)  | ({4{gnt_q[1]}} & M1_BA)  | ({4{gnt_q[2]}} & M2_BA);
    assign IBUS_WE = (gnt_q[0] & M0_WE) | (gnt_q[1] & M1_WE) | (gnt_q[2] & M2_WE);

    assign IBUS_REQ  = owner_req;
    assign IBUS_LOCK = owner_lock;

    assign M0_BUSY = M0_REQ & (~gnt_q[0] | IBUS_BUSY);
    assign M1_BUSY = M1_REQ & (~gnt_q[1] | IBUS_BUSY);
    assign M2_BUSY = M2_REQ & (~gnt_q[2] | IBUS_BUSY);

    assign M_DO = IBUS_DO;
    assign GNT  = gnt_q;

endmodule

// File: tb/tb_ibus_arbiter.sv
// Directed-vector bench for ibus_arbiter: reset, single access, arbitration order,
// lock holding, downstream stall, clock-enable gating and mid-transfer reset.
module tb_ibus_arbiter;

    logic        clk = 1'b0;
    logic        rst, ce_r, ce_f;
    logic [31:0] m_a [3];
    logic [31:0] m_di [3];
    logic [3:0]  m_ba [3];
    logic [2:0]  we, req, lock;
    logic [2:0]  busy;
    logic [31:0] m_do, ibus_a, ibus_di, ibus_do;
    logic [3:0]  ibus_ba;
    logic        ibus_we, ibus_req, ibus_lock, ibus_busy;
    logic [2:0]  gnt;

    int n_chk = 0;
    int n_bad = 0;
    logic [2:0] exp_order [3];

    always #5 clk = ~clk;

    ibus_arbiter dut (
        .CLK      (clk),
        .RST      (rst),
        .CE_R     (ce_r),
        .CE_F     (ce_f),
        .M0_A     (m_a[0]),
        .M0_DI    (m_di[0]),
        .M0_BA    (m_ba[0]),
        .M0_WE    (we[0]),
        .M0_REQ   (req[0]),
        .M0_LOCK  (lock[0]),
        .M0_BUSY  (busy[0]),
        .M1_A     (m_a[1]),
        .M1_DI    (m_di[1]),
        .M1_BA    (m_ba[1]),
        .M1_WE    (we[1]),
        .M1_REQ   (req[1]),
        .M1_LOCK  (lock[1]),
        .M1_BUSY  (busy[1]),
        .M2_A     (m_a[2]),
        .M2_DI    (m_di[2]),
        .M2_BA    (m_ba[2]),
        .M2_WE    (we[2]),
        .M2_REQ   (req[2]),
        .M2_LOCK  (lock[2]),
        .M2_BUSY  (busy[2]),
        .M_DO     (m_do),
        .IBUS_A   (ibus_a),
        .IBUS_DI  (ibus_di),
        .IBUS_BA  (ibus_ba),
        .IBUS_WE  (ibus_we),
        .IBUS_REQ (ibus_req),
        .IBUS_LOCK(ibus_lock),
        .IBUS_DO  (ibus_do),
        .IBUS_BUSY(ibus_busy),
        .GNT      (gnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce_r = 1'b1; ce_f = 1'b0;
        req = '0; lock = '0; we = '0;
        ibus_busy = 1'b0; ibus_do = 32'hdead_beef;
        m_a[0]  = 32'h1000_0000; m_a[1]  = 32'h2000_0004; m_a[2]  = 32'h3000_0008;
        m_di[0] = 32'haaaa_0000; m_di[1] = 32'hbbbb_1111; m_di[2] = 32'hcccc_2222;
        m_ba[0] = 4'h1;          m_ba[1] = 4'h3;          m_ba[2] = 4'hf;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_gnt", gnt, 3'b000);
        check("rst_req", ibus_req, 1'b0);
        check("rst_lock", ibus_lock, 1'b0);
        check("rst_a", ibus_a, 32'h0);
        check("rst_we", ibus_we, 1'b0);
        check("m_do", m_do, 32'hdead_beef);

        // Single master M1, read then release
        req[1] = 1'b1;
        #1 check("s_busy_pre", busy, 3'b010);
        tick();
        check("s_gnt", gnt, 3'b010);
        check("s_ireq", ibus_req, 1'b1);
        check("s_a", ibus_a, 32'h2000_0004);
        check("s_di", ibus_di, 32'hbbbb_1111);
        check("s_ba", ibus_ba, 4'h3);
        check("s_busy", busy[1], 1'b0);
        tick();
        check("s_gnt_idle", gnt, 3'b000);
        req[1] = 1'b0;
        #1 check("s_ireq_idle", ibus_req, 1'b0);

        // Simultaneous requests; LAST is now M1
`ifdef IBUS_ARB_RR_EN
        exp_order[0] = 3'b100; exp_order[1] = 3'b001; exp_order[2] = 3'b010;
`else
        exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100;
`endif
        req = 3'b111;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("prio_gnt%0d", k), gnt, exp_order[k]);
            check($sformatf("prio_busy%0d", k), busy, req & ~exp_order[k]);
            tick();
            check($sformatf("prio_idle%0d", k), gnt, 3'b000);
            req = req & ~exp_order[k];
        end

        // Locked TAS by M1 while M0 waits
        req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b0;
        tick();
        check("lk_gnt", gnt, 3'b010);
        req[0] = 1'b1;
        #1 check("lk_ilock", ibus_lock, 1'b1);
        check("lk_m0busy", busy[0], 1'b1);
        tick();
        check("lk_hold", gnt, 3'b010);
        check("lk_ireq2", ibus_req, 1'b1);
        check("lk_m0busy2", busy[0], 1'b1);
        lock[1] = 1'b0; we[1] = 1'b1;
        #1 check("lk_we", ibus_we, 1'b1);
        tick();
        check("lk_rel", gnt, 3'b000);
        check("lk_m0busy3", busy[0], 1'b1);
        req[1] = 1'b0; we[1] = 1'b0;
        tick();
        check("lk_m0gnt", gnt, 3'b001);
        check("lk_m0busy4", busy[0], 1'b0);
        tick();
        req[0] = 1'b0;

        // Lock held with owner idle: grant kept, no downstream request
        req[2] = 1'b1; lock[2] = 1'b1;
        tick();
        tick();
        check("lh_locked", gnt, 3'b100);
        req[2] = 1'b0; req[0] = 1'b1;
        tick();
        check("lh_hold", gnt, 3'b100);
        check("lh_ireq", ibus_req, 1'b0);
        check("lh_m0busy", busy[0], 1'b1);
        lock[2] = 1'b0;
        tick();
        check("lh_idle", gnt, 3'b000);
        tick();
        check("lh_m0gnt", gnt, 3'b001);
        tick();
        req[0] = 1'b0;

        // Downstream stall for 4 CE_R periods
        req[2] = 1'b1; ibus_busy = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("st_gnt%0d", k), gnt, 3'b100);
            check($sformatf("st_busy%0d", k), busy[2], 1'b1);
            tick();
        end
        ibus_busy = 1'b0;
        #1 check("st_busy_rel", busy[2], 1'b0);
        tick();
        check("st_done", gnt, 3'b000);
        req[2] = 1'b0;

        // No state change without CE_R
        ce_r = 1'b0; req[0] = 1'b1;
        tick(); tick();
        check("ce_gate", gnt, 3'b000);
        ce_r = 1'b1;
        tick();
        check("ce_gnt", gnt, 3'b001);

        // Reset while owning under a stall
        ibus_busy = 1'b1;
        tick();
        check("rm_own", gnt, 3'b001);
        rst = 1'b1;
        tick();
        check("rm_gnt", gnt, 3'b000);
        check("rm_ireq", ibus_req, 1'b0);
        rst = 1'b0; ibus_busy = 1'b0;
        tick();
        check("rm_regnt", gnt, 3'b001);
        tick();
        check("rm_done", gnt, 3'b000);
        req[0] = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
